// File: rtl/palette_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : palette_bank_if
//  Description : Bus bundle for palette_bank. Carries the scan-out read port,
//                the CPU entry-write handshake, the swap/frame controls and
//                the status flags.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals (master = scan-out/CPU side, slave = palette_bank):
//    rd_en, rd_addr        -> read one whole palette from the front bank
//    rd_data               <- packed palette, entry k at [k*ENTRY_W +: ENTRY_W]
//    wr_valid, wr_pal,
//    wr_idx, wr_data       -> single-entry write into the back bank
//    wr_ready              <- write accepted when wr_valid && wr_ready
//    swap_req, frame_start -> swap request pulse / frame boundary pulse
//    swap_pending, busy,
//    front_bank            <- status
// ============================================================================
interface palette_bank_if #(
  parameter int ENTRY_W  = 12,
  parameter int ENTRIES  = 16,
  parameter int PALETTES = 8
);
  localparam int PAL_W = (PALETTES > 1) ? $clog2(PALETTES) : 1;
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int ROW_W = ENTRIES * ENTRY_W;

  logic             rd_en;
  logic [PAL_W-1:0] rd_addr;
  logic [ROW_W-1:0] rd_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [PAL_W-1:0] wr_pal;
  logic [IDX_W-1:0] wr_idx;
  logic [ENTRY_W-1:0] wr_data;
  logic             swap_req;
  logic             frame_start;
  logic             swap_pending;
  logic             busy;
  logic             front_bank;

  modport master (
    output rd_en, rd_addr, wr_valid, wr_pal, wr_idx, wr_data, swap_req, frame_start,
    input  rd_data, wr_ready, swap_pending, busy, front_bank
  );

  modport slave (
    input  rd_en, rd_addr, wr_valid, wr_pal, wr_idx, wr_data, swap_req, frame_start,
    output rd_data, wr_ready, swap_pending, busy, front_bank
  );
endinterface
`default_nettype wire

// File: rtl/palette_bank.sv
`default_nettype none
// ============================================================================
//  Module      : palette_bank
//  Description : Double-buffered palette store. Scan-out reads whole palettes
//                from the front bank; the CPU writes single entries into the
//                back bank. Swaps are deferred to a frame boundary, after
//                which a copy engine refreshes the new back bank from the new
//                front bank, one row per cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports:
//    clk  - sole clock, rising edge
//    rst  - synchronous active-high reset
//    bus  - palette_bank_if.slave (read port, write handshake, swap control,
//           status flags)
// ============================================================================
module palette_bank #(
  parameter int ENTRY_W  = 12,
  parameter int ENTRIES  = 16,
  parameter int PALETTES = 8
) (
  input  logic           clk,
  input  logic           rst,
  palette_bank_if.slave  bus
);
  localparam int PAL_W = (PALETTES > 1) ? $clog2(PALETTES) : 1;
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int ROW_W = ENTRIES * ENTRY_W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_COPY = 1'b1
  } state_t;

  state_t           state_q;
  logic             front_q;
  logic             pending_q;
  logic             busy_q;
  logic             wr_ready_q;
  logic [PAL_W-1:0] cnt_q;
  logic [ROW_W-1:0] rd_data_q;

  // Bank storage; deliberately not reset.
  logic [ROW_W-1:0] mem_q [2][PALETTES];

  logic w_back;
  logic w_wr_fire;
  logic w_wr_pal_ok;
  logic w_rd_pal_ok;
  logic w_copy_last;

  assign w_back      = ~front_q;
  assign w_wr_fire   = bus.wr_valid && wr_ready_q;
  // The extra MSB keeps the compare meaningful when PALETTES is a power of 2.
  assign w_wr_pal_ok = ({1'b0, bus.wr_pal}  < (PAL_W+1)'(PALETTES));
  assign w_rd_pal_ok = ({1'b0, bus.rd_addr} < (PAL_W+1)'(PALETTES));
  assign w_copy_last = (cnt_q == PAL_W'(PALETTES - 1));

  // --------------------------------------------------------------------------
  // Control FSM with registered status outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      front_q    <= 1'b0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A swap_req arriving together with frame_start while nothing is
          // pending only arms the flag; the swap waits for the next frame.
          if (bus.frame_start && pending_q) begin
            front_q    <= ~front_q;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
            state_q    <= S_COPY;
          end else if (bus.swap_req) begin
            pending_q <= 1'b1;
          end
        end
        S_COPY: begin
          // frame_start is ignored here; requests are only recorded.
          if (bus.swap_req) begin
            pending_q <= 1'b1;
          end
          if (w_copy_last) begin
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bank writes: row copy during COPY, entry writes otherwise. Both target the
  // back bank as seen before the edge, so a write accepted on the swap edge
  // lands in the bank that is about to become front.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_COPY) begin
        mem_q[w_back][cnt_q] <= mem_q[front_q][cnt_q];
      end else if (w_wr_fire && w_wr_pal_ok) begin
        // Entry decode by constant slices; an out-of-range index matches none.
        for (int k = 0; k < ENTRIES; k++) begin
          if (bus.wr_idx == IDX_W'(k)) begin
            mem_q[w_back][bus.wr_pal][k*ENTRY_W +: ENTRY_W] <= bus.wr_data;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan-out read: one-cycle latency, held until the next request.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (bus.rd_en) begin
      rd_data_q <= w_rd_pal_ok ? mem_q[front_q][bus.rd_addr] : '0;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.wr_ready     = wr_ready_q;
  assign bus.swap_pending = pending_q;
  assign bus.busy         = busy_q;
  assign bus.front_bank   = front_q;

endmodule
`default_nettype wire

// File: tb/tb_palette_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palette_bank
//  Description : Self-checking bench for palette_bank. Read requests push the
//                expected palette row into a queue; a monitor pops and
//                compares one cycle after each accepted read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_palette_bank;
  localparam int ENTRY_W  = 12;
  localparam int ENTRIES  = 16;
  localparam int PALETTES = 8;
  localparam int ROW_W    = ENTRIES * ENTRY_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  palette_bank_if #(.ENTRY_W(ENTRY_W), .ENTRIES(ENTRIES), .PALETTES(PALETTES)) bus ();

  palette_bank #(.ENTRY_W(ENTRY_W), .ENTRIES(ENTRIES), .PALETTES(PALETTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [ROW_W-1:0] exp_q [$];
  logic [ROW_W-1:0] model [2][PALETTES];
  logic             mfront;
  logic             pend;

  task automatic chk_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a read accepted at an edge is compared just after that edge.
  initial begin
    forever begin
      @(posedge clk);
      pend = bus.rd_en && !rst;
      #1;
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_data: got %h expected nothing queued", bus.rd_data);
        end else begin
          chk_row("rd_data", bus.rd_data, exp_q.pop_front());
        end
      end
    end
  end

  // Every task starts just after a negedge and returns just after a negedge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int p, input int k, input logic [ENTRY_W-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_pal   = 3'(p);
    bus.wr_idx   = 4'(k);
    bus.wr_data  = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    model[~mfront][p][k*ENTRY_W +: ENTRY_W] = d;
  endtask

  task automatic rd(input int p);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 3'(p);
    exp_q.push_back(model[mfront][p]);
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic req();
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
  endtask

  // Applies a swap (swap_pending must already be set), optionally reading
  // palette 3 on the swap edge, then follows the copy while pulsing
  // swap_req / frame_start at the given copy-cycle indices (-1 = never).
  task automatic swap_frame(input bit do_rd, input int req_at, input int fs_at);
    int nb;
    int nr;
    bus.frame_start = 1'b1;
    if (do_rd) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 3'd3;
      exp_q.push_back(model[mfront][3]);
    end
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.rd_en       = 1'b0;
    mfront = ~mfront;
    for (int r = 0; r < PALETTES; r++) model[~mfront][r] = model[mfront][r];
    chk_bit("swap_front_bank", bus.front_bank, mfront);
    chk_bit("swap_pending_clr", bus.swap_pending, 1'b0);
    nb = 0;
    nr = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      nb++;
      if (!bus.wr_ready) nr++;
      bus.swap_req    = (i == req_at);
      bus.frame_start = (i == fs_at);
      @(negedge clk);
    end
    bus.swap_req    = 1'b0;
    bus.frame_start = 1'b0;
    chk_int("busy_cycles", nb, PALETTES);
    chk_int("wr_ready_low_cycles", nr, PALETTES);
    chk_bit("wr_ready_after_copy", bus.wr_ready, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.rd_en       = 1'b0;
    bus.rd_addr     = '0;
    bus.wr_valid    = 1'b0;
    bus.wr_pal      = '0;
    bus.wr_idx      = '0;
    bus.wr_data     = '0;
    bus.swap_req    = 1'b0;
    bus.frame_start = 1'b0;
    mfront          = 1'b0;
    idle(3);
    rst = 1'b0;

    // Fill bank 1 with a known pattern, swap so both banks hold it.
    for (int p = 0; p < PALETTES; p++)
      for (int k = 0; k < ENTRIES; k++)
        wr(p, k, 12'(12'h200 + p * 16 + k));
    req();
    swap_frame(1'b0, -1, -1);
    rd(3);
    idle(2);

    // Reset with front_bank=1 and non-zero rd_data.
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    mfront = 1'b0;
    chk_bit("rst_front_bank", bus.front_bank, 1'b0);
    chk_bit("rst_swap_pending", bus.swap_pending, 1'b0);
    chk_bit("rst_busy", bus.busy, 1'b0);
    chk_bit("rst_wr_ready", bus.wr_ready, 1'b1);
    chk_row("rst_rd_data", bus.rd_data, '0);
    idle(1);

    // Back-bank write is invisible to scan-out before a swap.
    wr(3, 5, 12'hABC);
    rd(3);
    chk_int("old_entry5", int'(bus.rd_data[5*ENTRY_W +: ENTRY_W]), 12'h235);

    // swap_req, then frame_start 10 cycles later; read on the swap edge
    // still sees the old front bank.
    req();
    idle(9);
    chk_bit("pending_before_frame", bus.swap_pending, 1'b1);
    swap_frame(1'b1, -1, -1);
    chk_bit("front_after_swap1", bus.front_bank, 1'b1);
    rd(3);
    chk_int("new_entry5", int'(bus.rd_data[5*ENTRY_W +: ENTRY_W]), 12'hABC);

    // Write the new back bank (bank 0), swap again: copied row preserved.
    wr(3, 0, 12'h123);
    req();
    swap_frame(1'b0, -1, -1);
    rd(3);
    chk_int("swap2_entry0", int'(bus.rd_data[0 +: ENTRY_W]), 12'h123);
    chk_int("swap2_entry5", int'(bus.rd_data[5*ENTRY_W +: ENTRY_W]), 12'hABC);

    // swap_req and frame_start in the same cycle: only arms the flag.
    bus.swap_req    = 1'b1;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.swap_req    = 1'b0;
    bus.frame_start = 1'b0;
    chk_bit("same_cycle_front", bus.front_bank, mfront);
    chk_bit("same_cycle_pending", bus.swap_pending, 1'b1);
    chk_bit("same_cycle_busy", bus.busy, 1'b0);
    idle(1);
    swap_frame(1'b1, -1, -1);

    // swap_req and frame_start during COPY: no swap until IDLE.
    req();
    swap_frame(1'b0, 1, 3);
    chk_bit("copy_fs_ignored_front", bus.front_bank, mfront);
    chk_bit("copy_req_pending", bus.swap_pending, 1'b1);
    idle(2);
    chk_bit("copy_fs_still_pending", bus.swap_pending, 1'b1);
    swap_frame(1'b0, -1, -1);
    rd(3);

    // Get front_bank to 0, then swap to 1 and reset on copy cycle 3.
    req();
    swap_frame(1'b0, -1, -1);
    rd(2);
    req();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk_bit("pre_abort_front", bus.front_bank, 1'b1);
    idle(2);
    chk_bit("copy_cycle3_busy", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    mfront = 1'b0;
    chk_bit("abort_busy", bus.busy, 1'b0);
    chk_bit("abort_wr_ready", bus.wr_ready, 1'b1);
    chk_bit("abort_front_bank", bus.front_bank, 1'b0);
    chk_bit("abort_swap_pending", bus.swap_pending, 1'b0);
    chk_row("abort_rd_data", bus.rd_data, '0);
    idle(3);
    chk_bit("abort_stays_idle", bus.busy, 1'b0);

    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
